transpose_stream: RTL



---
 rtl/transpose_stream.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/transpose_stream.sv
// Corner-turn buffer: ROWS row beats in, COLS transposed column beats out; TRANSPOSE_STREAM_PINGPONG_EN adds a second bank.
// First column one cycle after the last row; outputs hold while out_ready=0, in_ready drops while no bank is free.
module transpose_stream #(
  parameter int ROWS   = 4,
  parameter int COLS   = 8,
  parameter int ELEM_W = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [COLS*ELEM_W-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ROWS*ELEM_W-1:0] out_data,
  output logic                   out_last,
  output logic                   busy
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  typedef logic [ROWS-1:0][COLS*ELEM_W-1:0] bank_t;

  logic [RW-1:0] row_cnt_q, row_cnt_d;
  logic [CW-1:0] col_cnt_q, col_cnt_d;
  logic          in_fire, out_fire, row_done, col_done;
  bank_t         rd_bank;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign row_done = in_fire && (row_cnt_q == ROW_LAST);
  assign col_done = out_fire && (col_cnt_q == COL_LAST);
  assign out_last = out_valid && (col_cnt_q == COL_LAST);

  always_comb begin
    row_cnt_d = row_cnt_q;
    col_cnt_d = col_cnt_q;
    if (in_fire) row_cnt_d = row_done ? '0 : row_cnt_q + 1'b1;
    if (out_fire) col_cnt_d = col_done ? '0 : col_cnt_q + 1'b1;
    if (flush) begin
      row_cnt_d = '0;
      col_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_cnt_q <= '0;
      col_cnt_q <= '0;
    end else begin
      row_cnt_q <= row_cnt_d;
      col_cnt_q <= col_cnt_d;
    end
  end

  // Column select works purely from registered storage and col_cnt_q.
  always_comb begin
    out_data = '0;
    for (int j = 0; j < ROWS; j++) begin
      out_data[j*ELEM_W +: ELEM_W] = rd_bank[j][col_cnt_q*ELEM_W +: ELEM_W];
    end
  end

`ifdef TRANSPOSE_STREAM_PINGPONG_EN
  logic [1:0] full_q, full_d;
  logic       wr_bk_q, wr_bk_d;
  logic       rd_bk_q, rd_bk_d;
  bank_t      mem_q [2];

  assign in_ready  = !full_q[wr_bk_q];
  assign out_valid = full_q[rd_bk_q];
  assign busy      = (|full_q) || (row_cnt_q != '0);
  assign rd_bank   = mem_q[rd_bk_q];

  // A fill only completes into an empty bank and a drain only from a full one,
  // so both updates in one cycle always touch different banks.
  always_comb begin
    full_d  = full_q;
    wr_bk_d = wr_bk_q;
    rd_bk_d = rd_bk_q;
    if (row_done) begin
      full_d[wr_bk_q] = 1'b1;
      wr_bk_d         = !wr_bk_q;
    end
    if (col_done) begin
      full_d[rd_bk_q] = 1'b0;
      rd_bk_d         = !rd_bk_q;
    end
    if (flush) begin
      full_d  = '0;
      wr_bk_d = 1'b0;
      rd_bk_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q  <= '0;
      wr_bk_q <= 1'b0;
      rd_bk_q <= 1'b0;
      mem_q   <= '{default: '0};
    end else begin
      full_q  <= full_d;
      wr_bk_q <= wr_bk_d;
      rd_bk_q <= rd_bk_d;
      if (in_fire && !flush) mem_q[wr_bk_q][row_cnt_q] <= in_data;
    end
  end
`else
  typedef enum logic {FILL, DRAIN} state_t;

  state_t state_q, state_d;
  bank_t  mem_q;

  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q == DRAIN);
  assign busy      = (state_q == DRAIN) || (row_cnt_q != '0);
  assign rd_bank   = mem_q;

  always_comb begin
    state_d = state_q;
    if (row_done) state_d = DRAIN;
    if (col_done) state_d = FILL;
    if (flush) state_d = FILL;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FILL;
      mem_q   <= '0;
    end else begin
      state_q <= state_d;
      if (in_fire && !flush) mem_q[row_cnt_q] <= in_data;
    end
  end
`endif

endmodule
